// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : demux_pkg
// Purpose : Shared types and defaults for the 1:N stream demultiplexer.
//           slot_state_t : per-channel slot occupancy (EMPTY / FULL)
//           DEMUX_*      : default data width, channel count, counter width
// Rev     : 1.0  initial release
// ============================================================================
package demux_pkg;

    localparam int DEMUX_DATA_W_DEF = 4;
    localparam int DEMUX_N_OUT_DEF  = 4;
    localparam int DEMUX_CNT_W      = 16;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module  : demux_slot
// Purpose : One-entry registered output slot with valid/ready drain.
//           A load while the slot drains replaces the word with no bubble.
//           Optional (DEMUX_1N_CNT_EN) 16-bit wrapping drain counter.
// Ports   : clk, rst        clock, synchronous active-high reset
//           load, load_data write a new word into the slot
//           drain_ready     consumer ready
//           valid, data     slot full flag and stored word
//           cnt             drain count (only with DEMUX_1N_CNT_EN)
// Rev     : 1.0  initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   drain_ready,
    output logic                   valid,
    output logic [DATA_W-1:0]      data
`ifdef DEMUX_1N_CNT_EN
    ,
    output logic [DEMUX_CNT_W-1:0] cnt
`endif
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a load always leaves the slot full, even if it drains
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (load)             w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_drain && !load) w_state_nxt = SLOT_EMPTY;
            default:                          w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        valid = (r_state == SLOT_FULL);
    end

    assign w_drain = valid & drain_ready;

    // Data is only written on load, so it stays stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end
    end

    assign data = r_data;

`ifdef DEMUX_1N_CNT_EN
    logic [DEMUX_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + DEMUX_CNT_W'(1);
        end
    end

    assign cnt = r_cnt;
`endif

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_1n_stream.sv
`default_nettype none
// ============================================================================
// Module  : demux_1n_stream
// Purpose : Parametrised 1:N stream demultiplexer. Each accepted input word
//           is routed to the channel named by in_sel and held in that
//           channel's one-entry slot. A stalled channel only blocks words
//           addressed to it. Words with an out-of-range select are dropped
//           and flagged with a one-cycle sel_err pulse.
// Config  : DEMUX_1N_CNT_EN adds per-channel drain counters (cnt_out) and a
//           sel_err event counter (err_cnt), all 16-bit and wrapping.
// Ports   : clk, rst              clock, synchronous active-high reset
//           in_valid/in_ready     producer handshake
//           in_data, in_sel       producer word and destination channel
//           out_valid/out_ready   per-channel handshake (N_OUT bits)
//           out_data              channel k at [k*DATA_W +: DATA_W]
//           sel_err               dropped-word pulse
//           cnt_out, err_cnt      counters (only with DEMUX_1N_CNT_EN)
// Rev     : 1.0  initial release
// ============================================================================
module demux_1n_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF,
    parameter int N_OUT  = DEMUX_N_OUT_DEF,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [SEL_W-1:0]             in_sel,
    output logic [N_OUT-1:0]             out_valid,
    input  logic [N_OUT-1:0]             out_ready,
    output logic [N_OUT*DATA_W-1:0]      out_data,
    output logic                         sel_err
`ifdef DEMUX_1N_CNT_EN
    ,
    output logic [N_OUT*DEMUX_CNT_W-1:0] cnt_out,
    output logic [DEMUX_CNT_W-1:0]       err_cnt
`endif
);

    localparam int c_SEL_SPAN = 1 << SEL_W;

    logic [c_SEL_SPAN-1:0] w_valid_pad;
    logic [c_SEL_SPAN-1:0] w_ready_pad;
    logic                  w_sel_ok;
    logic                  w_xfer;
    logic                  w_drop;
    logic                  r_sel_err;

    // Pad the per-channel flags to the full select range so in_sel can index
    // them directly; unused codes read as empty.
    for (genvar i = 0; i < c_SEL_SPAN; i++) begin : g_pad
        if (i < N_OUT) begin : g_pad_hit
            assign w_valid_pad[i] = out_valid[i];
            assign w_ready_pad[i] = out_ready[i];
        end else begin : g_pad_miss
            assign w_valid_pad[i] = 1'b0;
            assign w_ready_pad[i] = 1'b0;
        end
    end

    // Every select code is a real channel when N_OUT is a power of two
    if (N_OUT == c_SEL_SPAN) begin : g_sel_full
        assign w_sel_ok = 1'b1;
    end else begin : g_sel_part
        assign w_sel_ok = (in_sel < SEL_W'(N_OUT));
    end

    // Out-of-range words are always accepted so they can be dropped
    assign in_ready = !rst && (!w_sel_ok || !w_valid_pad[in_sel] || w_ready_pad[in_sel]);
    assign w_xfer   = in_valid & in_ready;
    assign w_drop   = w_xfer & !w_sel_ok;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        logic w_load;
        assign w_load = w_xfer && w_sel_ok && (in_sel == SEL_W'(k));

        demux_slot #(
            .DATA_W      (DATA_W)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .load        (w_load),
            .load_data   (in_data),
            .drain_ready (out_ready[k]),
            .valid       (out_valid[k]),
            .data        (out_data[k*DATA_W +: DATA_W])
`ifdef DEMUX_1N_CNT_EN
            ,
            .cnt         (cnt_out[k*DEMUX_CNT_W +: DEMUX_CNT_W])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_drop;
        end
    end

    assign sel_err = r_sel_err;

`ifdef DEMUX_1N_CNT_EN
    logic [DEMUX_CNT_W-1:0] r_err_cnt;

    // Counts in step with the sel_err pulse being set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_drop) begin
            r_err_cnt <= r_err_cnt + DEMUX_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule : demux_1n_stream
`default_nettype wire
